// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: state encoding, default width and
// counter sizing.
package div_pkg;

  localparam int unsigned DefaultWidth    = 32;
  localparam int unsigned DefaultCntWidth = $clog2(DefaultWidth);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix,
    StDone
  } div_state_e;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/div_seq_sub_cla.sv
// Carry-lookahead subtractor: diff = a + ~b + 1 from 4-bit lookahead groups.
// cout = 1 means no borrow.
module sub_cla #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             cout
);
  localparam int unsigned NumGrp = WIDTH / 4;

  logic [WIDTH-1:0]  g, p, c;
  logic [NumGrp-1:0] grp_g, grp_p;
  logic [NumGrp:0]   grp_c;

  assign g = a & ~b;
  assign p = a ^ ~b;

  for (genvar k = 0; k < NumGrp; k++) begin : g_grp
    logic [3:0] gg, pp;
    logic       ci;
    assign gg = g[4*k +: 4];
    assign pp = p[4*k +: 4];
    assign ci = grp_c[k];
    assign c[4*k]   = ci;
    assign c[4*k+1] = gg[0] | (pp[0] & ci);
    assign c[4*k+2] = gg[1] | (pp[1] & gg[0]) | (&pp[1:0] & ci);
    assign c[4*k+3] = gg[2] | (pp[2] & gg[1]) | (&pp[2:1] & gg[0]) | (&pp[2:0] & ci);
    assign grp_g[k] = gg[3] | (pp[3] & gg[2]) | (&pp[3:2] & gg[1]) | (&pp[3:1] & gg[0]);
    assign grp_p[k] = &pp;
  end

  // Carry-in of 1 completes the two's-complement of b.
  always_comb begin
    grp_c    = '0;
    grp_c[0] = 1'b1;
    for (int unsigned k = 0; k < NumGrp; k++) begin
      grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
    end
  end

  assign diff = p ^ c;
  assign cout = grp_c[NumGrp];

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider, one quotient bit per cycle behind a start/done handshake.
// Two's-complement operation is compiled in with DIV_SIGNED_EN.
module div_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int unsigned      CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0]  CntLast = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0]  CntOne  = CntW'(1);
  localparam logic [WIDTH-1:0] One     = WIDTH'(1);

  div_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic             zero_q, zero_d;
  logic             done_q, dbz_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] sub_a, sub_b, sub_diff;
  logic             sub_cout, no_borrow, accept;

  // done_q still counts as busy so a start in the done cycle is dropped.
  assign accept    = (state_q == StIdle) && !done_q && start;
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  // The stored remainder is always below the divisor, so only R' can reach WIDTH+1 bits.
  assign no_borrow = rem_shift[WIDTH] | sub_cout;

`ifdef DIV_SIGNED_EN
  logic neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;

  // FIX reuses the subtractor as 0 - quotient.
  assign sub_a = (state_q == StFix) ? '0 : rem_shift[WIDTH-1:0];
  assign sub_b = (state_q == StFix) ? quo_q : dvs_q;
`else
  logic unused_signed_op;

  assign unused_signed_op = signed_op;
  assign sub_a = rem_shift[WIDTH-1:0];
  assign sub_b = dvs_q;
`endif

  sub_cla #(
    .WIDTH(WIDTH)
  ) u_sub (
    .a   (sub_a),
    .b   (sub_b),
    .diff(sub_diff),
    .cout(sub_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    zero_d  = zero_q;
`ifdef DIV_SIGNED_EN
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_d  = '0;
          rem_d  = '0;
          quo_d  = dividend;
          dvs_d  = divisor;
          zero_d = (divisor == '0);
`ifdef DIV_SIGNED_EN
          neg_quo_d = 1'b0;
          neg_rem_d = 1'b0;
          if (signed_op && (divisor != '0)) begin
            neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_d = dividend[WIDTH-1];
            if (dividend[WIDTH-1]) quo_d = ~dividend + One;
            if (divisor[WIDTH-1])  dvs_d = ~divisor + One;
          end
`endif
          state_d = (divisor == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        rem_d = no_borrow ? sub_diff : rem_shift[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], no_borrow};
        cnt_d = cnt_q + CntOne;
        if (cnt_q == CntLast) begin
`ifdef DIV_SIGNED_EN
          state_d = StFix;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef DIV_SIGNED_EN
      StFix: begin
        if (neg_quo_q) quo_d = sub_diff;
        if (neg_rem_q) rem_d = ~rem_q + One;
        state_d = StDone;
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      zero_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      zero_q  <= zero_d;
      done_q  <= (state_q == StDone);
      if (state_q == StDone) begin
        // The operand register still holds the raw dividend on the zero-divisor path.
        quotient_q  <= zero_q ? '1 : quo_q;
        remainder_q <= zero_q ? quo_q : rem_q;
        dbz_q       <= zero_q;
      end else if (accept) begin
        dbz_q <= 1'b0;
      end
    end
  end

`ifdef DIV_SIGNED_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end
`endif

  assign busy        = (state_q != StIdle) | done_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
